// File: rtl/seg_scan_mux.sv
// N-channel seven-segment digit scanner; frame-coherent data snapshot, live digit_en, optional dead time (SEG_SCAN_BLANK_EN).
// All outputs registered, 1-cycle latency from digit_en, up to one frame from data_in; no backpressure, free-running.
module seg_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int DATA_W       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_DIGITS*DATA_W-1:0]   data_in,
    input  logic [NUM_DIGITS-1:0]          digit_en,
    output logic [NUM_DIGITS-1:0]          an_n,
    output logic [DATA_W-1:0]              digit_out,
    output logic [$clog2(NUM_DIGITS)-1:0]  digit_idx,
    output logic                           frame_tick
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    // One counter serves both phases, so it is sized for the longer of the two.
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]             r_cnt;
    logic [IDX_W-1:0]             r_idx;
    logic [NUM_DIGITS*DATA_W-1:0] r_snap;
    logic                         r_first;

    logic [CNT_W-1:0]             w_cnt_nxt;
    logic [IDX_W-1:0]             w_idx_nxt;
    logic [NUM_DIGITS*DATA_W-1:0] w_snap_nxt;
    logic                         w_load;
    logic                         w_wrap;
    logic                         w_active;
    logic [DATA_W-1:0]            w_field;
    logic [NUM_DIGITS-1:0]        w_an_nxt;

`ifdef SEG_SCAN_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic {
        PH_BLANK  = 1'b0,
        PH_ACTIVE = 1'b1
    } phase_t;

    phase_t r_phase;
    phase_t w_phase_nxt;

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_phase_nxt = r_phase;
        w_load      = 1'b0;
        w_wrap      = 1'b0;
        if (r_first) begin
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_phase_nxt = PH_BLANK;
            w_load      = 1'b1;
        end else if (r_phase == PH_BLANK) begin
            if (r_cnt == BLANK_LAST) begin
                w_cnt_nxt   = '0;
                w_phase_nxt = PH_ACTIVE;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end else if (r_cnt == CNT_LAST) begin
            // End of the active window: next slot opens in BLANK.
            w_cnt_nxt   = '0;
            w_phase_nxt = PH_BLANK;
            if (r_idx == IDX_LAST) begin
                w_idx_nxt = '0;
                w_load    = 1'b1;
                w_wrap    = 1'b1;
            end else begin
                w_idx_nxt = r_idx + IDX_W'(1);
            end
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    assign w_active = (w_phase_nxt == PH_ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH_BLANK;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end
`else
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_idx_nxt = r_idx;
        w_load    = 1'b0;
        w_wrap    = 1'b0;
        if (r_first) begin
            w_cnt_nxt = '0;
            w_idx_nxt = '0;
            w_load    = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
            w_cnt_nxt = '0;
            if (r_idx == IDX_LAST) begin
                w_idx_nxt = '0;
                w_load    = 1'b1;
                w_wrap    = 1'b1;
            end else begin
                w_idx_nxt = r_idx + IDX_W'(1);
            end
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    assign w_active = 1'b1;
`endif

    // Decode from next-state values so the outputs change on the same edge as the slot.
    always_comb begin
        w_snap_nxt = w_load ? data_in : r_snap;
        w_field    = '0;
        w_an_nxt   = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_idx_nxt == IDX_W'(k)) begin
                w_field     = w_snap_nxt[k*DATA_W +: DATA_W];
                w_an_nxt[k] = ~(digit_en[k] & w_active);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_snap     <= '0;
            r_first    <= 1'b1;
            an_n       <= '1;
            digit_out  <= '0;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_snap     <= w_snap_nxt;
            r_first    <= 1'b0;
            an_n       <= w_an_nxt;
            digit_out  <= w_field;
            digit_idx  <= w_idx_nxt;
            frame_tick <= w_wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomised bench for seg_scan_mux; expected outputs come from a cycle-index model of the scan schedule.
module tb_seg_scan_mux;

    localparam int N   = 4;
    localparam int DW  = 4;
    localparam int DIV = 3;
`ifdef SEG_SCAN_BLANK_EN
    localparam int BL  = 2;
`else
    localparam int BL  = 0;
`endif
    localparam int SL  = BL + DIV;
    localparam int FL  = N * SL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [N*DW-1:0] data_in = '0;
    logic [N-1:0]  digit_en = '0;
    logic [N-1:0]  an_n;
    logic [DW-1:0] digit_out;
    logic [1:0]    digit_idx;
    logic          frame_tick;

    seg_scan_mux #(
        .NUM_DIGITS  (N),
        .DATA_W      (DW),
        .REFRESH_DIV (DIV),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .digit_en  (digit_en),
        .an_n      (an_n),
        .digit_out (digit_out),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int t     = 0;
    bit running = 1'b0;
    logic [N*DW-1:0] hist_dat [0:4095];
    logic [N-1:0]    hist_en  [0:4095];

    // Edge t (counted from the first edge after reset release) records the inputs the DUT saw.
    task automatic advance();
        @(posedge clk);
        if (rst_n) begin
            if (!running) begin
                running = 1'b1;
                t = 0;
            end else begin
                t = t + 1;
            end
            hist_dat[t] = data_in;
            hist_en[t]  = digit_en;
        end
        #1;
    endtask

    // Schedule: every SL cycles a new slot, every FL cycles a new frame whose data is
    // whatever data_in held on the frame's first edge; anodes lit only past the dead time.
    function automatic void model(input int tt, output logic [N-1:0] an, output logic [DW-1:0] dig,
                                  output logic [1:0] idx, output logic tick);
        int fs, slot, pos;
        logic [N*DW-1:0] snap;
        fs   = (tt / FL) * FL;
        slot = (tt % FL) / SL;
        pos  = tt % SL;
        snap = hist_dat[fs];
        dig  = DW'(snap >> (slot * DW));
        idx  = 2'(slot);
        an   = '1;
        if (pos >= BL && hist_en[tt][slot]) an[slot] = 1'b0;
        tick = (tt > 0) && (tt % FL == 0);
    endfunction

    task automatic test_reset();
        data_in  = 16'h4321;
        digit_en = 4'b1111;
        #2 rst_n = 1'b0;
        running  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            advance();
            total++;
            if ({an_n, digit_out, digit_idx, frame_tick} !== {4'b1111, 4'h0, 2'd0, 1'b0}) begin
                bad++;
                $display("FAIL reset cyc=%0d got an_n=%b dig=%h idx=%0d tick=%b exp an_n=1111 dig=0 idx=0 tick=0",
                         i, an_n, digit_out, digit_idx, frame_tick);
            end
        end
    endtask

    task automatic test_basic_scan();
        logic [N-1:0] e_an; logic [DW-1:0] e_dig; logic [1:0] e_idx; logic e_tick;
        rst_n = 1'b1;
        for (int i = 0; i < FL + SL; i++) begin
            advance();
            model(t, e_an, e_dig, e_idx, e_tick);
            total++;
            if ({an_n, digit_out, digit_idx, frame_tick} !== {e_an, e_dig, e_idx, e_tick}) begin
                bad++;
                $display("FAIL basic_scan t=%0d got an_n=%b dig=%h idx=%0d tick=%b exp an_n=%b dig=%h idx=%0d tick=%b",
                         t, an_n, digit_out, digit_idx, frame_tick, e_an, e_dig, e_idx, e_tick);
            end
        end
        // The literal first-frame pattern from 16'h4321: field 0 is 1 on the wrap edge.
        total++;
        if (digit_out !== 4'h1) begin
            bad++;
            $display("FAIL basic_first_field got dig=%h exp dig=1", digit_out);
        end
    endtask

    task automatic test_tearing();
        logic [N-1:0] e_an; logic [DW-1:0] e_dig; logic [1:0] e_idx; logic e_tick;
        bit changed = 1'b0;
        for (int i = 0; i < 3 * FL; i++) begin
            advance();
            model(t, e_an, e_dig, e_idx, e_tick);
            total++;
            if ({an_n, digit_out, digit_idx, frame_tick} !== {e_an, e_dig, e_idx, e_tick}) begin
                bad++;
                $display("FAIL tearing t=%0d got an_n=%b dig=%h idx=%0d tick=%b exp an_n=%b dig=%h idx=%0d tick=%b",
                         t, an_n, digit_out, digit_idx, frame_tick, e_an, e_dig, e_idx, e_tick);
            end
            if (!changed && (t % FL) / SL == 1) begin
                data_in = 16'hABCD;
                changed = 1'b1;
            end
        end
        if (!changed) begin
            total++;
            bad++;
            $display("FAIL tearing_wait got no slot-1 window within %0d cycles exp one", 3 * FL);
        end
    endtask

    task automatic test_mask();
        logic [N-1:0] e_an; logic [DW-1:0] e_dig; logic [1:0] e_idx; logic e_tick;
        digit_en = 4'b0101;
        for (int i = 0; i < FL + SL; i++) begin
            advance();
            model(t, e_an, e_dig, e_idx, e_tick);
            total++;
            if ({an_n, digit_out, digit_idx, frame_tick} !== {e_an, e_dig, e_idx, e_tick}) begin
                bad++;
                $display("FAIL mask t=%0d got an_n=%b dig=%h idx=%0d tick=%b exp an_n=%b dig=%h idx=%0d tick=%b",
                         t, an_n, digit_out, digit_idx, frame_tick, e_an, e_dig, e_idx, e_tick);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] e_an; logic [DW-1:0] e_dig; logic [1:0] e_idx; logic e_tick;
        for (int i = 0; i < 240; i++) begin
            if ($urandom_range(3, 0) == 0) data_in = 16'($urandom);
            if ($urandom_range(2, 0) == 0) digit_en = 4'($urandom);
            advance();
            model(t, e_an, e_dig, e_idx, e_tick);
            total++;
            if ({an_n, digit_out, digit_idx, frame_tick} !== {e_an, e_dig, e_idx, e_tick}) begin
                bad++;
                $display("FAIL random t=%0d got an_n=%b dig=%h idx=%0d tick=%b exp an_n=%b dig=%h idx=%0d tick=%b",
                         t, an_n, digit_out, digit_idx, frame_tick, e_an, e_dig, e_idx, e_tick);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] e_an; logic [DW-1:0] e_dig; logic [1:0] e_idx; logic e_tick;
        bit found = 1'b0;
        digit_en = 4'b1111;
        for (int i = 0; i < 2 * FL && !found; i++) begin
            advance();
            // Slot 2, second cycle of its active window.
            if ((t % FL) / SL == 2 && (t % SL) == BL + 1) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL reset_mid_wait got no slot-2 cnt-1 point within %0d cycles exp one", 2 * FL);
        end
        rst_n   = 1'b0;
        running = 1'b0;
        #1;
        total++;
        if ({an_n, digit_out, digit_idx, frame_tick} !== {4'b1111, 4'h0, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_async got an_n=%b dig=%h idx=%0d tick=%b exp an_n=1111 dig=0 idx=0 tick=0",
                     an_n, digit_out, digit_idx, frame_tick);
        end
        advance();
        advance();
        data_in = 16'h9E57;
        rst_n   = 1'b1;
        for (int i = 0; i < FL + SL; i++) begin
            advance();
            model(t, e_an, e_dig, e_idx, e_tick);
            total++;
            if ({an_n, digit_out, digit_idx, frame_tick} !== {e_an, e_dig, e_idx, e_tick}) begin
                bad++;
                $display("FAIL reset_mid_restart t=%0d got an_n=%b dig=%h idx=%0d tick=%b exp an_n=%b dig=%h idx=%0d tick=%b",
                         t, an_n, digit_out, digit_idx, frame_tick, e_an, e_dig, e_idx, e_tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_tearing();
        test_mask();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
